// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared constants, FSM encoding and request type for the    |
// |           data-memory burst initiator.                               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam int MEM_ADDR_W      = 16;
  localparam int MEM_DATA_W      = 16;
  localparam int MEM_DEPTH_WORDS = 4096;
  localparam int MEM_LEN_W       = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_TAIL = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_FIN     = 3'd4;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_LEN_W-1:0]  len;
  } mem_req_t;

  function automatic int unsigned burst_beats(input logic [MEM_LEN_W-1:0] len);
    return int'(len) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_addr_gen : latches the burst base/length, steps the beat counter |
// |                and checks alignment and RAM range of a request.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_addr_gen
  import mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int LEN_W     = MEM_LEN_W,
  parameter int MEM_WORDS = MEM_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_fault,
  output logic              o_err,
  output logic              o_last,
  output logic [ADDR_W-1:0] o_mem_addr
);

  localparam int CW = ADDR_W + 1;

  logic [ADDR_W-2:0] r_base;
  logic [LEN_W:0]    r_beat;
  logic [LEN_W-1:0]  r_len;
  logic              r_err;

  logic [CW-1:0]     w_end_word;
  logic [ADDR_W-2:0] w_word;

  // End word computed one bit wider than the address so an overrun cannot wrap.
  assign w_end_word = {2'b00, i_addr[ADDR_W-1:1]} + CW'(i_len);
  assign o_fault    = i_addr[0] | (w_end_word >= CW'(MEM_WORDS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base <= '0;
      r_beat <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
    end else if (i_load) begin
      r_base <= i_addr[ADDR_W-1:1];
      r_beat <= '0;
      r_len  <= i_len;
      r_err  <= o_fault;
    end else if (i_step) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  assign w_word     = r_base + (ADDR_W-1)'(r_beat);
  assign o_mem_addr = {w_word, 1'b0};
  assign o_last     = (r_beat == {1'b0, r_len});
  assign o_err      = r_err;

endmodule
`default_nettype wire

// File: rtl/mem_burst_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_burst_initiator : turns single/burst load-store requests into    |
// |                       word accesses on the synchronous data RAM.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MEM_WORDS = MEM_DEPTH_WORDS,
  parameter int LEN_W     = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rd_valid;
  logic              r_rd_last;

  logic              w_accept;
  logic              w_issue_rd;
  logic              w_wr_fire;
  logic              w_fault;
  logic              w_err_lat;
  logic              w_last;
  logic [ADDR_W-1:0] w_gen_addr;

  mem_addr_gen #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_step     (w_issue_rd | w_wr_fire),
    .i_addr     (req_addr),
    .i_len      (req_len),
    .o_fault    (w_fault),
    .o_err      (w_err_lat),
    .o_last     (w_last),
    .o_mem_addr (w_gen_addr)
  );

  // Outputs are qualified with rst_n so a reset mid-burst stops RAM writes at once.
  assign req_ready  = rst_n && (r_state == ST_IDLE);
  assign wr_ready   = rst_n && (r_state == ST_WR);
  assign w_accept   = req_valid && req_ready;
  assign w_issue_rd = rst_n && (r_state == ST_RD);
  assign w_wr_fire  = wr_valid && wr_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_fault)        w_state_nxt = ST_FIN;
          else if (req_write) w_state_nxt = ST_WR;
          else                w_state_nxt = ST_RD;
        end
      end
      ST_RD:      if (w_last) w_state_nxt = ST_RD_TAIL;
      ST_RD_TAIL: w_state_nxt = ST_IDLE;
      ST_WR:      if (w_wr_fire && w_last) w_state_nxt = ST_FIN;
      ST_FIN:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= w_issue_rd;
      r_rd_last  <= w_issue_rd && w_last;
    end
  end

  // RAM returns data one cycle after the address, so the return flags trail the issue.
  assign rd_valid  = rst_n && r_rd_valid;
  assign rd_last   = rst_n && r_rd_last;
  assign rd_data   = mem_rdata;

  assign done      = rst_n && ((r_state == ST_FIN) || r_rd_last);
  assign err       = rst_n && (r_state == ST_FIN) && w_err_lat;
  assign busy      = rst_n && (r_state != ST_IDLE);

  assign mem_we    = w_wr_fire;
  assign mem_wdata = w_wr_fire ? wr_data : '0;
  assign mem_addr  = (w_issue_rd || wr_ready) ? w_gen_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_burst_initiator : self-checking bench with a RAM model and a  |
// |                          word-array reference of memory contents.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_burst_initiator;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_last, done, err, busy, mem_we;
  logic [15:0] rd_data, mem_addr, mem_wdata, mem_rdata;

  logic [15:0] ram     [0:MEM_DEPTH_WORDS-1];
  logic [15:0] ref_mem [0:MEM_DEPTH_WORDS-1];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_burst_initiator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous read-first RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[12:1]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[12:1]];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Runs one burst and checks every cycle against the expected protocol timeline.
  task automatic run_burst(input logic wr, input logic [15:0] addr, input logic [3:0] len,
                           input logic [15:0] wbase, input logic [31:0] stall,
                           output int done_cyc, output logic err_seen);
    int   nbeats;
    int   c;
    int   k;
    logic fault;
    nbeats   = int'(burst_beats(len));
    fault    = addr[0] || ((int'(addr >> 1) + int'(len)) >= MEM_DEPTH_WORDS);
    done_cyc = -1;
    err_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; wr_valid = 1'b0;
    #1 check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    if (fault) begin
      wr_valid = wr; wr_data = wbase;
      #1;
      check("fault_done", done, 1);
      check("fault_err", err, 1);
      check("fault_we", mem_we, 0);
      check("fault_rdv", rd_valid, 0);
      check("fault_wr_ready", wr_ready, 0);
      check("fault_busy", busy, 1);
      if (done) done_cyc = 1;
      err_seen = err;
    end else if (!wr) begin
      for (c = 1; c <= nbeats + 1; c++) begin
        if (c > 1) @(negedge clk);
        #1;
        check("rd_we", mem_we, 0);
        check("rd_addr", mem_addr, (c <= nbeats) ? 16'(int'(addr) + 2 * (c - 1)) : 16'h0);
        check("rd_valid", rd_valid, (c >= 2) ? 1 : 0);
        if (c >= 2) check("rd_data", rd_data, ref_mem[int'(addr >> 1) + c - 2]);
        check("rd_last", rd_last, (c == nbeats + 1) ? 1 : 0);
        check("rd_done", done, (c == nbeats + 1) ? 1 : 0);
        check("rd_busy", busy, 1);
        if (done && done_cyc < 0) done_cyc = c;
        if (err) err_seen = 1'b1;
      end
    end else begin
      c = 1; k = 0;
      while (k < nbeats && c < 64) begin
        if (c > 1) @(negedge clk);
        wr_valid = !stall[c % 32];
        wr_data  = wbase + 16'(k);
        #1;
        check("wr_ready", wr_ready, 1);
        check("wr_we", mem_we, wr_valid);
        check("wr_done_early", done, 0);
        if (wr_valid) begin
          check("wr_addr", mem_addr, 16'(int'(addr) + 2 * k));
          check("wr_wdata", mem_wdata, wbase + 16'(k));
          ref_mem[int'(addr >> 1) + k] = wbase + 16'(k);
          k++;
        end
        c++;
      end
      check("wr_beats", k, nbeats);
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      check("wr_done", done, 1);
      check("wr_we_fin", mem_we, 0);
      if (done) done_cyc = c;
      err_seen = err;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("ready_after", req_ready, 1);
    check("done_after", done, 0);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  len;
    logic [15:0] wbase;
    logic [31:0] stall;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int       dc;
    logic     es;
    mem_req_t rq;
    int       sel;

    for (int i = 0; i < MEM_DEPTH_WORDS; i++) begin
      ram[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end

    vecs[0] = '{1'b1, 16'h0010, 4'd3,  16'h00A1, 32'h0,                 1'b0, 5};
    vecs[1] = '{1'b0, 16'h0010, 4'd3,  16'h0000, 32'h0,                 1'b0, 5};
    vecs[2] = '{1'b1, 16'h0020, 4'd3,  16'h00B1, 32'h18,                1'b0, 7};
    vecs[3] = '{1'b0, 16'h0020, 4'd3,  16'h0000, 32'h0,                 1'b0, 5};
    vecs[4] = '{1'b1, 16'h0003, 4'd3,  16'h1111, 32'h0,                 1'b1, 1};
    vecs[5] = '{1'b0, 16'h1FFE, 4'd1,  16'h0000, 32'h0,                 1'b1, 1};
    vecs[6] = '{1'b0, 16'h1FE0, 4'd15, 16'h0000, 32'h0,                 1'b0, 17};
    vecs[7] = '{1'b1, 16'h1FFE, 4'd0,  16'h5A5A, 32'h0,                 1'b0, 2};

    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010;
    req_len = 4'd3; wr_valid = 1'b1; wr_data = 16'hFFFF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; wr_valid = 1'b0;
    #1 check("rel_req_ready", req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wbase, vecs[i].stall, dc, es);
      check($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      check($sformatf("vec%0d_err", i), es, vecs[i].exp_err);
    end

    // Reset during beat 2 of a store: beats 0 and 1 land, the rest must not.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_len = 4'd3;
    @(negedge clk);
    req_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'h00C0;
    #1 check("mr_we0", mem_we, 1);
    ref_mem[16'h20] = 16'h00C0;
    @(negedge clk);
    wr_data = 16'h00C1;
    #1 check("mr_we1", mem_we, 1);
    ref_mem[16'h21] = 16'h00C1;
    @(negedge clk);
    wr_data = 16'h00C2; rst_n = 1'b0;
    #1;
    check("mr_we_rst", mem_we, 0);
    check("mr_wr_ready_rst", wr_ready, 0);
    check("mr_addr_rst", mem_addr, 0);
    check("mr_wdata_rst", mem_wdata, 0);
    check("mr_busy_rst", busy, 0);
    check("mr_done_rst", done, 0);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    #1;
    check("mr_ready_rel", req_ready, 1);
    check("mr_done_rel", done, 0);
    check("mr_we_rel", mem_we, 0);
    run_burst(1'b0, 16'h0040, 4'd3, 16'h0, 32'h0, dc, es);
    check("mr_readback_done", dc, 5);

    for (int n = 0; n < 40; n++) begin
      sel      = int'($urandom_range(0, 9));
      rq.write = 1'($urandom_range(0, 1));
      rq.len   = 4'($urandom_range(0, 15));
      if (sel == 0)      rq.addr = 16'($urandom_range(0, 16'h1FFF)) | 16'h1;
      else if (sel == 1) rq.addr = 16'h1FE0 + 16'(2 * $urandom_range(0, 15));
      else               rq.addr = 16'h0200 + 16'(2 * $urandom_range(0, 31));
      run_burst(rq.write, rq.addr, rq.len, 16'($urandom), $urandom & 32'h5555_5554, dc, es);
      check("rnd_err",
            es, (rq.addr[0] || ((int'(rq.addr >> 1) + int'(rq.len)) >= MEM_DEPTH_WORDS)) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_burst_initiator.md
Name: mem_burst_initiator

Overview:
Initiator side of the data-memory port: turns single or burst load/store requests from the core or a DMA client into word-accesses on the synchronous 16-bit data RAM.
- RAM contract: byte address, word index = addr>>1, read-first, 1-cycle read latency, write on we at posedge.
- Block handles address stepping, read-latency alignment, write-data flow control and range/alignment checking.
- Sits between pipeline MEM stage / DMA and the data RAM.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, data word width.
- MEM_WORDS, 4096, RAM depth in words; range-check limit.
- LEN_W, 4, burst-length field width; beats = req_len+1, so max 16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  request can be accepted.
- req_write  in  1  1=store burst, 0=load burst.
- req_addr  in  ADDR_W  byte start address.
- req_len  in  LEN_W  beats minus one.
- wr_valid  in  1  store data beat offered.
- wr_ready  out  1  store data beat accepted.
- wr_data  in  DATA_W  store data.
- rd_valid  out  1  load data beat valid; no backpressure.
- rd_data  out  DATA_W  load data.
- rd_last  out  1  marks final load beat.
- done  out  1  one-cycle pulse: burst finished.
- err  out  1  one-cycle pulse with done: request rejected.
- busy  out  1  high in any non-IDLE state.
- mem_we  out  1  to RAM write enable.
- mem_addr  out  ADDR_W  to RAM byte address; always even.
- mem_wdata  out  DATA_W  to RAM write data.
- mem_rdata  in  DATA_W  from RAM, valid one cycle after address.

Behaviour:
- Interface clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset:
  - While rst_n=0: state=IDLE; req_ready, wr_ready, rd_valid, rd_last, done, err, busy and mem_we are all 0; mem_addr=0; mem_wdata=0.
  - Reset mid-burst abandons the burst immediately: no further mem_we, no done.
- States: IDLE, RD, RD_TAIL, WR, FIN.
- Registers: base word index, beat counter (LEN_W+1 bits), latched length, latched error flag.
- req_ready=1 only in IDLE (and not in reset). Acceptance occurs at an edge where req_valid&&req_ready; call the accepting edge cycle T.
- Error check on acceptance: fault if req_addr[0]=1, or (req_addr>>1)+req_len >= MEM_WORDS (evaluated at 17 bits, no wrap). On fault: go to FIN, no RAM activity; at T+1 done=1 and err=1.
- Load (RD):
  - From T+1 for L=req_len+1 cycles, mem_addr = req_addr + 2*beat, beat=0..L-1.
  - mem_we=0 throughout.
  - After the last issue, go to RD_TAIL for one cycle, then IDLE.
- Load data return:
  - rd_valid is the issue flag delayed 1 cycle; rd_data = mem_rdata passthrough.
  - Beat k appears at T+2+k.
  - rd_last and done are both asserted with beat L-1, at T+1+L.
- Store (WR):
  - wr_ready=1 in WR.
  - mem_we = wr_valid&&wr_ready; mem_wdata = wr_data; mem_addr = req_addr + 2*beat.
  - beat increments only on an accepted beat; wr_valid gaps stall without writing.
  - After the last accepted beat go to FIN; done pulses the following cycle.
- FIN lasts 1 cycle (done pulse), then IDLE. req_ready returns the cycle after done, giving a min 1-cycle gap between bursts.
- Outside an active issue: mem_addr=0, mem_we=0.
- Read-after-write ordering is automatic: bursts never overlap, so RAM read-first hazards cannot occur.
- Address arithmetic is modulo 2^ADDR_W. Wrap is unreachable because of the range check.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE,RD,RD_TAIL,WR,FIN};
  - MEM_WORDS, DATA_W, ADDR_W constants;
  - request struct (write, addr, len).
- One natural sub-module: mem_addr_gen, holding base latch, beat counter, last-beat flag and range/alignment check.

Test Plan:
- Store 4 beats: req_addr=0x0010, len=3, data 0xA1..0xA4 with wr_valid continuous → mem_we at T+1..T+4 to 0x10, 0x12, 0x14, 0x16; done at T+5; err=0.
- Load back the same burst → rd_valid at T+2..T+5 with data 0xA1..0xA4; rd_last and done at T+5.
- Store with wr_valid low for 2 cycles mid-burst → no mem_we during the gap; addresses still contiguous; done one cycle after the 4th write.
- Misaligned req_addr=0x0003, or end beyond word 4095 (req_addr=0x1FFE, len=1) → no mem_we, no rd_valid; done=err=1 at T+1.
- Boundary: req_addr=0x1FE0, len=15 load → accepted; last mem_addr=0x1FFE; 16 beats returned.
- rst_n=0 during beat 2 of a store → no further mem_we; outputs at reset values; req_ready=1 the cycle after release.
